// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I opcodes, control encodings and enums
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] A_RS1  = 2'b00;
  localparam logic [1:0] A_PC   = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] PC_TRAP  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    C_R,
    C_I,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_LUI,
    C_AUIPC
  } iclass_e;

endpackage

// File: rtl/multicycle_control_unit_classifier.sv
// rtl/multicycle_control_unit_classifier.sv - combinational opcode to instruction class decode
import rv32i_pkg::*;

module opcode_classifier #(
  parameter int ENABLE_JUMPS = 1
) (
  input  logic [6:0] opcode_i,
  output iclass_e    iclass_o,
  output logic       illegal_o
);

  logic jump_class;

  always_comb begin
    iclass_o   = C_R;
    illegal_o  = 1'b0;
    jump_class = 1'b0;
    case (opcode_i)
      OP_R:      iclass_o = C_R;
      OP_I:      iclass_o = C_I;
      OP_LOAD:   iclass_o = C_LOAD;
      OP_STORE:  iclass_o = C_STORE;
      OP_BRANCH: iclass_o = C_BRANCH;
      OP_JAL:    begin iclass_o = C_JAL;   jump_class = 1'b1; end
      OP_JALR:   begin iclass_o = C_JALR;  jump_class = 1'b1; end
      OP_LUI:    begin iclass_o = C_LUI;   jump_class = 1'b1; end
      OP_AUIPC:  begin iclass_o = C_AUIPC; jump_class = 1'b1; end
      default:   illegal_o = 1'b1;
    endcase
    // Jump and upper-immediate classes are only legal when the datapath supports them
    if (jump_class && (ENABLE_JUMPS == 0)) illegal_o = 1'b1;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control sequencer with bus-timeout and illegal-opcode traps
import rv32i_pkg::*;

module multicycle_control_unit #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int ENABLE_JUMPS = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  input  logic             trap_clear,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_a_src,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_e             state_q, state_d;
  iclass_e            class_q, class_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q;

  iclass_e            dec_class;
  logic               dec_illegal;

  logic       imem_req_c, ir_write_c, dmem_req_c, mem_read_c, mem_write_c;
  logic       reg_write_c, mem_to_reg_c, alu_src_c, pc_write_c, trap_c;
  logic [1:0] alu_a_src_c, alu_op_c, pc_src_c;

  opcode_classifier #(
    .ENABLE_JUMPS(ENABLE_JUMPS)
  ) u_classifier (
    .opcode_i (opcode),
    .iclass_o (dec_class),
    .illegal_o(dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      class_q   <= C_R;
      wait_q    <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      // The trap-exit PC redirect is not an instruction completion
      if (pc_write_c && (state_q != S_TRAP)) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    wait_d       = wait_q;
    cause_d      = cause_q;
    imem_req_c   = 1'b0;
    ir_write_c   = 1'b0;
    dmem_req_c   = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    reg_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_c    = 1'b0;
    alu_a_src_c  = A_RS1;
    alu_op_c     = ALU_ADD;
    pc_write_c   = 1'b0;
    pc_src_c     = PC_PLUS4;
    trap_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      S_DECODE: begin
        if (dec_illegal) begin
          cause_d = CAUSE_ILLEGAL;
          state_d = S_TRAP;
        end else begin
          class_d = dec_class;
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        case (class_q)
          C_R:     alu_op_c = ALU_RTYPE;
          C_I:     begin alu_op_c = ALU_ITYPE; alu_src_c = 1'b1; end
          C_LOAD,
          C_STORE: begin alu_src_c = 1'b1; state_d = S_MEM; end
          C_JALR:  alu_src_c = 1'b1;
          C_BRANCH: begin
            alu_op_c   = ALU_BRANCH;
            pc_write_c = 1'b1;
            pc_src_c   = branch_taken ? PC_IMM : PC_PLUS4;
            state_d    = S_FETCH;
          end
          C_JAL:   begin pc_write_c = 1'b1; pc_src_c = PC_IMM; end
          C_LUI:   begin alu_a_src_c = A_ZERO; alu_src_c = 1'b1; end
          C_AUIPC: begin alu_a_src_c = A_PC;   alu_src_c = 1'b1; end
          default: state_d = S_WRITEBACK;
        endcase
      end

      S_MEM: begin
        dmem_req_c  = 1'b1;
        mem_read_c  = (class_q == C_LOAD);
        mem_write_c = (class_q == C_STORE);
        if (dmem_ready) begin
          if (class_q == C_STORE) begin
            pc_write_c = 1'b1;
            pc_src_c   = PC_PLUS4;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      S_WRITEBACK: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = (class_q == C_LOAD);
        // JAL already redirected the PC in EXECUTE
        if (class_q != C_JAL) begin
          pc_write_c = 1'b1;
          pc_src_c   = (class_q == C_JALR) ? PC_ALU : PC_PLUS4;
        end
        state_d = S_FETCH;
      end

      S_TRAP: begin
        trap_c = 1'b1;
        if (trap_clear) begin
          pc_write_c = 1'b1;
          pc_src_c   = PC_TRAP;
          cause_d    = CAUSE_NONE;
          state_d    = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase

    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) wait_d = '0;
  end

  // Reset state is FETCH, so every strobe is gated to keep the bus quiet while held in reset
  assign imem_req   = rst_n & imem_req_c;
  assign ir_write   = rst_n & ir_write_c;
  assign dmem_req   = rst_n & dmem_req_c;
  assign mem_read   = rst_n & mem_read_c;
  assign mem_write  = rst_n & mem_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign mem_to_reg = rst_n & mem_to_reg_c;
  assign alu_src    = rst_n & alu_src_c;
  assign alu_a_src  = {2{rst_n}} & alu_a_src_c;
  assign alu_op     = {2{rst_n}} & alu_op_c;
  assign pc_write   = rst_n & pc_write_c;
  assign pc_src     = {2{rst_n}} & pc_src_c;
  assign trap       = rst_n & trap_c;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
